i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
//  I2S master transmitter: downstream of the DDS test tone / audio source. Generates MCLK,
//  BCLK and LRCLK from the 48MHz system clock and issues the audio-rate sample request.
//  Serialises the returned 32-bit stereo word {L[15:0],R[15:0]} onto SD in standard I2S
//  (Philips) format: 16-bit slots, 32 BCLK per frame, MSB one BCLK after each LRCLK edge.
// PARAMETERS
//  BCLK_DIV    16  i_clk cycles per BCLK half-period; power of two, >=2 (48MHz/32 -> 1.5MHz BCLK)
//  MCLK_SHIFT  2   o_mclk = i_clk / 2**MCLK_SHIFT (12MHz = 256*fs at defaults); 1..log2(BCLK_DIV)
//  REQ_LEAD    4   i_clk cycles between o_sample_req pulse and the load cycle; 2..2*BCLK_DIV-1
// PORTS
//  i_clk         in   1   system clock, 48MHz
//  i_rst         in   1   synchronous active-high reset
//  i_en          in   1   enable; low = idle line, counter held at 0
//  i_sample      in   32  stereo sample, [31:16] left, [15:0] right, two's complement
//  o_sample_req  out  1   one-cycle request pulse, once per frame
//  o_mclk        out  1   codec master clock
//  o_bclk        out  1   bit clock
//  o_lrclk       out  1   word select, 0 = left, 1 = right
//  o_sd          out  1   serial data, changes only on BCLK falling edge
// BEHAVIOUR
//  - Single free-running counter cyc, 0..FRAME_CYC-1, FRAME_CYC = 64*BCLK_DIV (1024 default),
//    wraps to 0. All outputs are registered and updated together with cyc: zero relative skew.
//  - Derived: o_bclk = cyc[log2(BCLK_DIV)] (low first half, high second half of each bit);
//    slot b = cyc / (2*BCLK_DIV), 0..31; o_lrclk = (b >= 16); o_mclk = cyc[MCLK_SHIFT-1].
//  - Falling BCLK edge = start of slot. At start of slot 1 (cyc = 2*BCLK_DIV, the load cycle):
//    shift reg <= i_sample, o_sd <= i_sample[31]. Each later slot start: shift left,
//    o_sd <= next bit. Slot 0 of next frame carries right LSB (i_sample[0]).
//  - o_sample_req high for exactly one cycle at cyc = 2*BCLK_DIV - REQ_LEAD (28 default);
//    i_sample is sampled only in the load cycle; changes at any other time have no effect.
//    Source must present a stable word by the load cycle (test tone registers it 1 cycle after req).
//  - Effective fs = 48MHz / FRAME_CYC = 46.875kHz at defaults.
//  - Reset (any cycle, including mid-frame): next cycle cyc=0, shift reg=0, o_sample_req=0,
//    o_mclk=0, o_bclk=0, o_lrclk=0, o_sd=0. On release, frame restarts at cyc 0; slot 0 of the
//    first frame transmits 0; first req at cyc 28.
//  - i_en low: identical to reset state, held while low; no req issued. i_en rising restarts at cyc 0.
//    i_rst has priority over i_en.
//  - No partial frames after restart: the first loaded word is always complete L then R.
// STRUCTURE
//  - audio_pkg: FRAME_BITS=32, SLOT_BITS=16, typedef stereo_sample_t {logic[15:0] l, r}
//    (packed, l in [31:16]); shared with test tone and future audio sources.
//  - Single module, no sub-module: one counter, one shift register, one output register bank.
//  - Elaboration-time asserts on BCLK_DIV power of two, MCLK_SHIFT and REQ_LEAD ranges.
// TESTING  (defaults: BCLK_DIV=16, MCLK_SHIFT=2, REQ_LEAD=4)
//  - Reset 5 cycles, release -> all outputs 0 during reset; req at cycles 28, 1052, 2076 after
//    release, exactly one cycle wide; o_bclk period 32, o_lrclk period 1024, o_mclk period 4.
//  - Drive i_sample=32'hA5A5_3C3C -> I2S receiver model (samples SD on BCLK rise, MSB one bit
//    after LRCLK edge) decodes L=16'hA5A5, R=16'h3C3C; SD stable across every BCLK high phase.
//  - Connect DDS tone model, fcw=16'h0100 -> decoded L=R, increasing by 16'h0100 per frame,
//    wraps 16'hFF00 -> 16'h0000 with no dropped or repeated frame.
//  - Toggle i_sample to 32'hFFFF_FFFF everywhere except load cycle (32'h0000_0001 there) ->
//    decoded L=16'h0000, R=16'h0001.
//  - Assert i_rst at cyc=500 for 1 cycle -> all outputs 0 next cycle; following req 28 cycles
//    after release; first decoded frame equals the sample presented at the new load cycle.
//  - Drop i_en at cyc=700 for 100 cycles -> outputs 0, no req while low; restart as after reset.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions for the I2S transmitter, the DDS test tone and
// any future audio sources: frame geometry and the packed stereo word.
package audio_pkg;

  // Bits per stereo frame on the I2S line and bits per channel slot.
  localparam int FRAME_BITS = 32;
  localparam int SLOT_BITS  = 16;

  // Stereo word as exchanged between sources and the transmitter.
  // Left channel sits in the upper half ([31:16]), right in the lower half.
  typedef struct packed {
    logic [SLOT_BITS-1:0] l;
    logic [SLOT_BITS-1:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_tx.sv
// I2S (Philips) master transmitter. One free-running frame counter drives
// every output; MCLK, BCLK, LRCLK and the sample request are decoded from
// the counter's next value and registered together with it, so all outputs
// move on the same i_clk edge with no relative skew. The serial data is the
// MSB of a shift register that is loaded or shifted only on BCLK falling
// edges, one BCLK after each LRCLK transition.
//
// The "load cycle" is the i_clk edge on which the counter enters
// 2*BCLK_DIV: i_sample is captured there, so the source must hold a stable
// word during the preceding cycle (REQ_LEAD >= 2 leaves room for a source
// that registers its word one cycle after the request).
module i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV   = 16,
  parameter int MCLK_SHIFT = 2,
  parameter int REQ_LEAD   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [FRAME_BITS-1:0] i_sample,
  output logic                  o_sample_req,
  output logic                  o_mclk,
  output logic                  o_bclk,
  output logic                  o_lrclk,
  output logic                  o_sd
);

  // Frame geometry derived from the BCLK divider.
  localparam int BCLK_SHIFT = $clog2(BCLK_DIV);
  localparam int SLOT_CYC   = 2 * BCLK_DIV;
  localparam int FRAME_CYC  = FRAME_BITS * SLOT_CYC;
  localparam int CYC_W      = $clog2(FRAME_CYC);

  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(FRAME_CYC - 1);
  localparam logic [CYC_W-1:0] LOAD_CYC = CYC_W'(SLOT_CYC);
  localparam logic [CYC_W-1:0] REQ_CYC  = CYC_W'(SLOT_CYC - REQ_LEAD);

  // Reject parameter sets that would break the clock decode or the
  // request-to-load handshake.
  if (BCLK_DIV < 2 || (BCLK_DIV & (BCLK_DIV - 1)) != 0) begin : g_bad_bclk_div
    $error("i2s_tx: BCLK_DIV must be a power of two and at least 2");
  end
  if (MCLK_SHIFT < 1 || MCLK_SHIFT > BCLK_SHIFT) begin : g_bad_mclk_shift
    $error("i2s_tx: MCLK_SHIFT must lie in 1..log2(BCLK_DIV)");
  end
  if (REQ_LEAD < 2 || REQ_LEAD > SLOT_CYC - 1) begin : g_bad_req_lead
    $error("i2s_tx: REQ_LEAD must lie in 2..2*BCLK_DIV-1");
  end

  logic [CYC_W-1:0]      cyc;
  logic [CYC_W-1:0]      cyc_next;
  logic                  slot_start;
  logic [FRAME_BITS-1:0] shift_reg;
  stereo_sample_t        sample_word;

  assign sample_word = stereo_sample_t'(i_sample);

  // A slot begins where BCLK falls, i.e. where the low counter bits wrap.
  assign slot_start = (cyc_next[BCLK_SHIFT:0] == '0);

  // The data line is the top of the shift register, already a flop output.
  assign o_sd = shift_reg[FRAME_BITS-1];

  // Next counter value: wraps at the end of a frame, parked at 0 while disabled.
  always_comb begin
    cyc_next = cyc + CYC_W'(1);
    if (!i_en || cyc == LAST_CYC) begin
      cyc_next = '0;
    end
  end

  // Counter and clock/request output bank, all decoded from the next count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc          <= '0;
      o_sample_req <= 1'b0;
      o_mclk       <= 1'b0;
      o_bclk       <= 1'b0;
      o_lrclk      <= 1'b0;
    end else begin
      cyc          <= cyc_next;
      o_sample_req <= i_en && (cyc_next == REQ_CYC);
      o_mclk       <= cyc_next[MCLK_SHIFT-1];
      o_bclk       <= cyc_next[BCLK_SHIFT];
      o_lrclk      <= cyc_next[CYC_W-1];
    end
  end

  // Serialiser: capture the stereo word at the start of slot 1, shift on
  // every other slot start so slot 0 of the next frame carries the right LSB.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      shift_reg <= '0;
    end else if (cyc_next == LOAD_CYC) begin
      shift_reg <= sample_word;
    end else if (slot_start) begin
      shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx at default parameters. A driver answers each sample
// request according to the active source mode and pushes the word it expects
// on the line; an I2S receiver model decodes SD on BCLK rises into a second
// queue. Each test task compares the two queues and its own timing figures.
module tb_i2s_tx;

  localparam int FRAME       = 1024;
  localparam int MODE_CONST  = 0;
  localparam int MODE_DDS    = 1;
  localparam int MODE_TOGGLE = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic [31:0] i_sample;
  logic        o_sample_req;
  logic        o_mclk;
  logic        o_bclk;
  logic        o_lrclk;
  logic        o_sd;

  int n_cmp = 0;
  int n_bad = 0;

  // Driver / scoreboard state.
  int          drv_mode = MODE_CONST;
  logic [31:0] pattern_word = 32'h0;
  logic [15:0] dds_phase = 16'h0;
  logic [15:0] dds_fcw = 16'h0100;
  int          cyc_count = 0;
  int          since_req = -1;
  int          req_log[$];
  logic [31:0] exp_q[$];

  // Receiver model state.
  logic [31:0] rx_q[$];
  logic [15:0] rx_shift = 16'h0;
  logic [15:0] rx_l = 16'h0;
  logic        prev_bclk = 1'b0;
  logic        prev_lr = 1'b0;
  logic        have_l = 1'b0;
  logic        hi_sd = 1'b0;
  int          sd_glitch = 0;

  i2s_tx dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_sample     (i_sample),
    .o_sample_req (o_sample_req),
    .o_mclk       (o_mclk),
    .o_bclk       (o_bclk),
    .o_lrclk      (o_lrclk),
    .o_sd         (o_sd)
  );

  // 100 MHz-style bench clock; only cycle counts matter here.
  always #5 i_clk = ~i_clk;

  // I2S receiver: sample SD on BCLK rise; an LRCLK change seen at a rise
  // marks that bit as the LSB of the channel just finished.
  always @(negedge i_clk) begin
    if (i_rst || !i_en) begin
      rx_shift  = 16'h0;
      prev_bclk = 1'b0;
      prev_lr   = 1'b0;
      have_l    = 1'b0;
    end else begin
      if (o_bclk && !prev_bclk) begin
        hi_sd    = o_sd;
        rx_shift = {rx_shift[14:0], o_sd};
        if (o_lrclk !== prev_lr) begin
          if (o_lrclk) begin
            rx_l   = rx_shift;
            have_l = 1'b1;
          end else if (have_l) begin
            rx_q.push_back({rx_l, rx_shift});
            have_l = 1'b0;
          end
          prev_lr = o_lrclk;
        end
      end else if (o_bclk && prev_bclk && (o_sd !== hi_sd)) begin
        sd_glitch++;
      end
      prev_bclk = o_bclk;
    end
  end

  // Forget everything recorded so far; called whenever the DUT restarts at cyc 0.
  task automatic restart_counts();
    cyc_count = 0;
    since_req = -1;
    req_log.delete();
    exp_q.delete();
    rx_q.delete();
    sd_glitch = 0;
  endtask

  // One i_clk cycle: observe the request, then drive the source for the next edge.
  task automatic advance();
    logic req_now;
    @(negedge i_clk);
    #1;
    cyc_count++;
    req_now = (o_sample_req === 1'b1);
    if (req_now) begin
      req_log.push_back(cyc_count);
      since_req = 0;
    end else if (since_req >= 0) begin
      since_req++;
    end
    case (drv_mode)
      MODE_DDS: begin
        if (since_req == 1) begin
          i_sample = {dds_phase, dds_phase};
          exp_q.push_back({dds_phase, dds_phase});
          dds_phase = dds_phase + dds_fcw;
        end
      end
      MODE_TOGGLE: begin
        if (since_req == 3) begin
          i_sample = 32'h0000_0001;
          exp_q.push_back(32'h0000_0001);
        end else begin
          i_sample = 32'hFFFF_FFFF;
        end
      end
      default: begin
        i_sample = pattern_word;
        if (req_now) exp_q.push_back(pattern_word);
      end
    endcase
  endtask

  // Hold reset for n cycles and release; the DUT sits at cyc 0 on return.
  task automatic reset_dut(input int n);
    i_rst = 1'b1;
    repeat (n) begin
      @(negedge i_clk);
      #1;
    end
    i_rst = 1'b0;
    restart_counts();
  endtask

  // Reset values, request timing and clock periods after release.
  task automatic test_reset();
    int exp_req[3];
    int bclk_r[$];
    int lr_r[$];
    int mclk_r[$];
    logic pb, pl, pm;
    int got;
    exp_req = '{28, 1052, 2076};
    drv_mode = MODE_CONST;
    pattern_word = 32'h0;
    i_en = 1'b1;
    i_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      #1;
      n_cmp++;
      if ({o_sample_req, o_mclk, o_bclk, o_lrclk, o_sd} !== 5'b0) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %b expected 00000", i,
                 {o_sample_req, o_mclk, o_bclk, o_lrclk, o_sd});
      end
    end
    i_rst = 1'b0;
    restart_counts();
    pb = 1'b0;
    pl = 1'b0;
    pm = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      advance();
      if (o_bclk && !pb) bclk_r.push_back(cyc_count);
      if (o_lrclk && !pl) lr_r.push_back(cyc_count);
      if (o_mclk && !pm) mclk_r.push_back(cyc_count);
      pb = o_bclk;
      pl = o_lrclk;
      pm = o_mclk;
    end
    n_cmp++;
    if (req_log.size() != 3) begin
      n_bad++;
      $display("[TB] FAIL req_count: got %0d expected 3", req_log.size());
    end
    for (int k = 0; k < 3; k++) begin
      got = (k < req_log.size()) ? req_log[k] : -1;
      n_cmp++;
      if (got != exp_req[k]) begin
        n_bad++;
        $display("[TB] FAIL req_position %0d: got %0d expected %0d", k, got, exp_req[k]);
      end
    end
    got = (bclk_r.size() >= 2) ? bclk_r[1] - bclk_r[0] : -1;
    n_cmp++;
    if (got != 32) begin
      n_bad++;
      $display("[TB] FAIL bclk_period: got %0d expected 32", got);
    end
    got = (bclk_r.size() >= 1) ? bclk_r[0] : -1;
    n_cmp++;
    if (got != 16) begin
      n_bad++;
      $display("[TB] FAIL bclk_first_rise: got %0d expected 16", got);
    end
    got = (lr_r.size() >= 2) ? lr_r[1] - lr_r[0] : -1;
    n_cmp++;
    if (got != 1024) begin
      n_bad++;
      $display("[TB] FAIL lrclk_period: got %0d expected 1024", got);
    end
    got = (lr_r.size() >= 1) ? lr_r[0] : -1;
    n_cmp++;
    if (got != 512) begin
      n_bad++;
      $display("[TB] FAIL lrclk_first_rise: got %0d expected 512", got);
    end
    got = (mclk_r.size() >= 2) ? mclk_r[1] - mclk_r[0] : -1;
    n_cmp++;
    if (got != 4) begin
      n_bad++;
      $display("[TB] FAIL mclk_period: got %0d expected 4", got);
    end
  endtask

  // Constant stereo word decoded by the receiver model.
  task automatic test_pattern();
    logic [31:0] got, exp;
    reset_dut(5);
    drv_mode = MODE_CONST;
    pattern_word = 32'hA5A5_3C3C;
    repeat (3 * FRAME + 24) advance();
    n_cmp++;
    if (rx_q.size() != 3 || exp_q.size() != 3) begin
      n_bad++;
      $display("[TB] FAIL pattern_frames: got %0d decoded expected 3 (pushed %0d)",
               rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("[TB] FAIL pattern_word: got L=%h R=%h expected L=%h R=%h",
                 got[31:16], got[15:0], exp[31:16], exp[15:0]);
      end
    end
    n_cmp++;
    if (sd_glitch != 0) begin
      n_bad++;
      $display("[TB] FAIL sd_stable_bclk_high: got %0d changes expected 0", sd_glitch);
    end
  endtask

  // DDS tone source answering each request one cycle late, across a phase wrap.
  task automatic test_dds();
    logic [31:0] got, exp;
    logic [15:0] prev_l;
    logic        have_prev;
    logic        saw_wrap;
    reset_dut(5);
    drv_mode = MODE_DDS;
    dds_phase = 16'hF000;
    dds_fcw = 16'h0100;
    have_prev = 1'b0;
    saw_wrap = 1'b0;
    prev_l = 16'h0;
    repeat (20 * FRAME + 24) advance();
    n_cmp++;
    if (rx_q.size() != 20 || exp_q.size() != 20) begin
      n_bad++;
      $display("[TB] FAIL dds_frames: got %0d decoded expected 20 (pushed %0d)",
               rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("[TB] FAIL dds_word: got L=%h R=%h expected L=%h R=%h",
                 got[31:16], got[15:0], exp[31:16], exp[15:0]);
      end
      if (have_prev && prev_l == 16'hFF00 && got[31:16] == 16'h0000) saw_wrap = 1'b1;
      prev_l = got[31:16];
      have_prev = 1'b1;
    end
    n_cmp++;
    if (saw_wrap !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL dds_wrap: got %b expected 1 (FF00 followed by 0000)", saw_wrap);
    end
  endtask

  // i_sample only matters on the load edge; all-ones everywhere else.
  task automatic test_load_only();
    logic [31:0] got, exp;
    reset_dut(5);
    drv_mode = MODE_TOGGLE;
    i_sample = 32'hFFFF_FFFF;
    repeat (3 * FRAME + 24) advance();
    n_cmp++;
    if (rx_q.size() != 3 || exp_q.size() != 3) begin
      n_bad++;
      $display("[TB] FAIL load_frames: got %0d decoded expected 3 (pushed %0d)",
               rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("[TB] FAIL load_word: got L=%h R=%h expected L=%h R=%h",
                 got[31:16], got[15:0], exp[31:16], exp[15:0]);
      end
    end
  endtask

  // One-cycle reset in the middle of a frame.
  task automatic test_mid_reset();
    int got_req;
    logic [31:0] got;
    reset_dut(5);
    drv_mode = MODE_CONST;
    pattern_word = 32'h1234_5678;
    repeat (500) advance();
    i_rst = 1'b1;
    @(negedge i_clk);
    #1;
    n_cmp++;
    if ({o_sample_req, o_mclk, o_bclk, o_lrclk, o_sd} !== 5'b0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset_outputs: got %b expected 00000",
               {o_sample_req, o_mclk, o_bclk, o_lrclk, o_sd});
    end
    i_rst = 1'b0;
    restart_counts();
    pattern_word = 32'hC0DE_0B0E;
    repeat (FRAME + 24) advance();
    got_req = (req_log.size() == 1) ? req_log[0] : -1;
    n_cmp++;
    if (got_req != 28) begin
      n_bad++;
      $display("[TB] FAIL mid_reset_req: got %0d (count %0d) expected 28 (count 1)",
               got_req, req_log.size());
    end
    got = (rx_q.size() == 1) ? rx_q[0] : 32'hxxxx_xxxx;
    n_cmp++;
    if (got !== 32'hC0DE_0B0E || exp_q.size() != 1) begin
      n_bad++;
      $display("[TB] FAIL mid_reset_frame: got %h (count %0d) expected c0de0b0e (count 1)",
               got, rx_q.size());
    end
  endtask

  // Enable dropped for 100 cycles: idle line, no request, clean restart.
  task automatic test_enable_gap();
    int got_req;
    int idle_bad;
    logic [31:0] got;
    reset_dut(5);
    drv_mode = MODE_CONST;
    pattern_word = 32'h8001_7FFE;
    repeat (700) advance();
    i_en = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      #1;
      n_cmp++;
      if ({o_sample_req, o_mclk, o_bclk, o_lrclk, o_sd} !== 5'b0) begin
        n_bad++;
        idle_bad++;
        if (idle_bad <= 4) begin
          $display("[TB] FAIL enable_low_outputs cycle %0d: got %b expected 00000", i,
                   {o_sample_req, o_mclk, o_bclk, o_lrclk, o_sd});
        end
      end
    end
    i_en = 1'b1;
    restart_counts();
    pattern_word = 32'h5A5A_F00F;
    repeat (FRAME + 24) advance();
    got_req = (req_log.size() == 1) ? req_log[0] : -1;
    n_cmp++;
    if (got_req != 28) begin
      n_bad++;
      $display("[TB] FAIL enable_restart_req: got %0d (count %0d) expected 28 (count 1)",
               got_req, req_log.size());
    end
    got = (rx_q.size() == 1) ? rx_q[0] : 32'hxxxx_xxxx;
    n_cmp++;
    if (got !== 32'h5A5A_F00F || exp_q.size() != 1) begin
      n_bad++;
      $display("[TB] FAIL enable_restart_frame: got %h (count %0d) expected 5a5af00f (count 1)",
               got, rx_q.size());
    end
  endtask

  // Test sequence.
  initial begin
    i_rst = 1'b1;
    i_en = 1'b1;
    i_sample = 32'h0;
    test_reset();
    test_pattern();
    test_dds();
    test_load_only();
    test_mid_reset();
    test_enable_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
